// File: rtl/ddr3_mch_pkg.sv
// Shared command codes, burst geometry and controller state encoding for the
// multi-channel DDR3 read/write controller.
package ddr3_mch_pkg;

    localparam logic [3:0]  CMD_RD          = 4'b0001;
    localparam logic [3:0]  CMD_WR          = 4'b0010;
    localparam int unsigned BEATS_PER_BURST = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_CMD   = 2'd2,
        S_WDATA = 2'd3
    } state_t;

    // A burst count of zero encodes the maximum of 32 bursts.
    function automatic int unsigned burst_beats(input int unsigned blen);
        return ((blen == 0) ? 32 : blen) * BEATS_PER_BURST;
    endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// Show-ahead synchronous FIFO holding {channel, beat count} tags for reads
// that have been issued but whose data has not fully returned.
module ddr3_tag_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_dout  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_mch_rw_ctrl.sv
// Round-robin arbiter that multiplexes CH_NUM user request channels onto one
// DDR3 IP command/data port and routes returned read data by tag order.
module ddr3_mch_rw_ctrl
    import ddr3_mch_pkg::*;
#(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned DDR_DW    = 64,
    parameter int unsigned DDR_AW    = 26,
    parameter int unsigned DDR_BLW   = 5,
    parameter int unsigned DM_WIDTH  = 8,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CH_NUM-1:0]         i_req_valid,
    input  logic [CH_NUM-1:0]         i_req_wr,
    input  logic [CH_NUM*DDR_AW-1:0]  i_req_addr,
    input  logic [CH_NUM*DDR_BLW-1:0] i_req_blen,
    output logic [CH_NUM-1:0]         o_req_ready,
    input  logic [CH_NUM*DDR_DW-1:0]  i_wdata,
    output logic [CH_NUM-1:0]         o_wdata_rd,
    output logic [DDR_DW-1:0]         o_rdata,
    output logic [CH_NUM-1:0]         o_rdata_valid,
    output logic                      o_err,
    input  logic                      i_init_done,
    input  logic                      i_cmd_rdy,
    input  logic                      i_datain_rdy,
    input  logic                      i_rdata_valid,
    input  logic [DDR_DW-1:0]         i_rdata,
    output logic [CMD_WIDTH-1:0]      o_cmd,
    output logic [DDR_AW-1:0]         o_addr,
    output logic [DDR_BLW-1:0]        o_cmd_burst_cnt,
    output logic                      o_cmd_valid,
    output logic                      o_ofly_burst_len,
    output logic [DDR_DW-1:0]         o_ddr3_wdata,
    output logic [DM_WIDTH-1:0]       o_data_mask
);
    localparam int unsigned CH_W  = $clog2(CH_NUM);
    localparam int unsigned BT_W  = DDR_BLW + 2;
    localparam int unsigned TAG_W = CH_W + BT_W;

    function automatic logic [CH_NUM-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    endfunction

    state_t              state;
    logic [CH_W-1:0]     last_grant;
    logic [CH_W-1:0]     grant_ch;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_found;
    logic [CH_NUM-1:0]   eligible;
    int unsigned         cand;
    logic                cur_wr;
    logic [BT_W-1:0]     cur_beats;
    logic [BT_W-1:0]     wbeats;
    logic [DDR_BLW-1:0]  req_blen;
    logic [BT_W-1:0]     req_beats;
    logic                tag_push;
    logic                tag_pop;
    logic                tag_full;
    logic                tag_empty;
    logic [TAG_W-1:0]    tag_din;
    logic [TAG_W-1:0]    tag_dout;
    logic [CH_W-1:0]     head_ch;
    logic [BT_W-1:0]     head_beats;
    logic [BT_W-1:0]     rd_cnt;

    assign eligible = i_req_valid & (i_req_wr | {CH_NUM{!tag_full}});

    // Search starts one past the previous winner so every channel gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            cand = 32'(last_grant) + 1 + i;
            if (cand >= CH_NUM) cand = cand - CH_NUM;
            if (!grant_found && eligible[CH_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

    assign req_blen  = i_req_blen[grant_idx*DDR_BLW +: DDR_BLW];
    assign req_beats = BT_W'(burst_beats(32'(req_blen)));

    assign o_wdata_rd   = (state == S_WDATA && i_datain_rdy) ? ch_onehot(grant_ch) : '0;
    assign o_ddr3_wdata = (state == S_WDATA) ? i_wdata[grant_ch*DDR_DW +: DDR_DW] : '0;
    assign o_data_mask      = '0;
    assign o_ofly_burst_len = 1'b0;

    assign tag_push = (state == S_CMD) && i_cmd_rdy && !cur_wr;
    assign tag_din  = {grant_ch, cur_beats};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            last_grant      <= CH_W'(CH_NUM - 1);
            grant_ch        <= '0;
            cur_wr          <= 1'b0;
            cur_beats       <= '0;
            wbeats          <= '0;
            o_req_ready     <= '0;
            o_cmd           <= '0;
            o_addr          <= '0;
            o_cmd_burst_cnt <= '0;
            o_cmd_valid     <= 1'b0;
        end else begin
            o_req_ready <= '0;
            case (state)
                S_IDLE: begin
                    if (i_init_done) state <= S_ARB;
                end
                S_ARB: begin
                    if (!i_init_done) begin
                        state <= S_IDLE;
                    end else if (grant_found) begin
                        o_req_ready     <= ch_onehot(grant_idx);
                        last_grant      <= grant_idx;
                        grant_ch        <= grant_idx;
                        cur_wr          <= i_req_wr[grant_idx];
                        cur_beats       <= req_beats;
                        o_cmd           <= i_req_wr[grant_idx] ? CMD_WIDTH'(CMD_WR) : CMD_WIDTH'(CMD_RD);
                        o_addr          <= i_req_addr[grant_idx*DDR_AW +: DDR_AW];
                        o_cmd_burst_cnt <= req_blen;
                        o_cmd_valid     <= 1'b1;
                        state           <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (i_cmd_rdy) begin
                        o_cmd_valid <= 1'b0;
                        if (cur_wr) begin
                            wbeats <= cur_beats;
                            state  <= S_WDATA;
                        end else begin
                            state <= S_ARB;
                        end
                    end
                end
                S_WDATA: begin
                    if (i_datain_rdy) begin
                        wbeats <= wbeats - 1'b1;
                        if (wbeats == BT_W'(1)) state <= S_ARB;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read return path: data belongs to the oldest outstanding tag.
    assign head_ch    = tag_dout[TAG_W-1 -: CH_W];
    assign head_beats = tag_dout[BT_W-1:0];
    assign tag_pop    = i_rdata_valid && !tag_empty && (BT_W'(rd_cnt + 1'b1) == head_beats);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_cnt        <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= '0;
            o_err         <= 1'b0;
        end else begin
            o_rdata_valid <= '0;
            if (i_rdata_valid) begin
                if (tag_empty) begin
                    o_err <= 1'b1;
                end else begin
                    o_rdata       <= i_rdata;
                    o_rdata_valid <= ch_onehot(head_ch);
                    rd_cnt        <= tag_pop ? '0 : rd_cnt + 1'b1;
                end
            end
        end
    end

    ddr3_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (tag_push),
        .i_din   (tag_din),
        .i_pop   (tag_pop),
        .o_dout  (tag_dout),
        .o_full  (tag_full),
        .o_empty (tag_empty)
    );

endmodule

// File: tb/tb_ddr3_mch_rw_ctrl.sv
// Scoreboard bench for ddr3_mch_rw_ctrl: stimulus pushes expected grants,
// commands, write beats and read returns; a negedge monitor pops and compares.
module tb_ddr3_mch_rw_ctrl;
    import ddr3_mch_pkg::*;

    localparam int CH  = 4;
    localparam int DW  = 64;
    localparam int AW  = 26;
    localparam int BLW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [CH-1:0]     req_valid = '0;
    logic [CH-1:0]     req_wr = '0;
    logic [CH*AW-1:0]  req_addr = '0;
    logic [CH*BLW-1:0] req_blen = '0;
    logic [CH*DW-1:0]  wdata = '0;
    logic              init_done = 1'b0;
    logic              cmd_rdy = 1'b0;
    logic              datain_rdy = 1'b0;
    logic              rdata_valid = 1'b0;
    logic [DW-1:0]     rdata = '0;

    logic [CH-1:0]     o_req_ready;
    logic [CH-1:0]     o_wdata_rd;
    logic [DW-1:0]     o_rdata;
    logic [CH-1:0]     o_rdata_valid;
    logic              o_err;
    logic [3:0]        o_cmd;
    logic [AW-1:0]     o_addr;
    logic [BLW-1:0]    o_cmd_burst_cnt;
    logic              o_cmd_valid;
    logic              o_ofly_burst_len;
    logic [DW-1:0]     o_ddr3_wdata;
    logic [7:0]        o_data_mask;

    ddr3_mch_rw_ctrl #(
        .CH_NUM    (CH),
        .CMD_WIDTH (4),
        .DDR_DW    (DW),
        .DDR_AW    (AW),
        .DDR_BLW   (BLW),
        .DM_WIDTH  (8),
        .TAG_DEPTH (8)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_wr         (req_wr),
        .i_req_addr       (req_addr),
        .i_req_blen       (req_blen),
        .o_req_ready      (o_req_ready),
        .i_wdata          (wdata),
        .o_wdata_rd       (o_wdata_rd),
        .o_rdata          (o_rdata),
        .o_rdata_valid    (o_rdata_valid),
        .o_err            (o_err),
        .i_init_done      (init_done),
        .i_cmd_rdy        (cmd_rdy),
        .i_datain_rdy     (datain_rdy),
        .i_rdata_valid    (rdata_valid),
        .i_rdata          (rdata),
        .o_cmd            (o_cmd),
        .o_addr           (o_addr),
        .o_cmd_burst_cnt  (o_cmd_burst_cnt),
        .o_cmd_valid      (o_cmd_valid),
        .o_ofly_burst_len (o_ofly_burst_len),
        .o_ddr3_wdata     (o_ddr3_wdata),
        .o_data_mask      (o_data_mask)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [3:0] cmd; logic [AW-1:0] addr; logic [BLW-1:0] blen; } cmd_t;
    typedef struct { int ch; logic [DW-1:0] d; } wd_t;
    typedef struct { int ch; logic [DW-1:0] d; int cyc; } rd_t;

    int   gq[$];
    cmd_t cq[$];
    wd_t  wq[$];
    rd_t  rq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output event must match the head of its queue.
    int   mg;
    cmd_t mc;
    wd_t  mw;
    rd_t  mr;
    always @(negedge clk) begin
        if (o_req_ready != '0) begin
            if (gq.size() == 0) chk("grant_unexpected", 64'(o_req_ready), 64'd0);
            else begin
                mg = gq.pop_front();
                chk("grant", 64'(o_req_ready), 64'd1 << mg);
            end
        end
        if (o_cmd_valid && cmd_rdy) begin
            if (cq.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
            else begin
                mc = cq.pop_front();
                chk("cmd", 64'(o_cmd), 64'(mc.cmd));
                chk("cmd_addr", 64'(o_addr), 64'(mc.addr));
                chk("cmd_blen", 64'(o_cmd_burst_cnt), 64'(mc.blen));
            end
        end
        if (o_wdata_rd != '0) begin
            if (wq.size() == 0) chk("wdata_rd_unexpected", 64'(o_wdata_rd), 64'd0);
            else begin
                mw = wq.pop_front();
                chk("wdata_rd", 64'(o_wdata_rd), 64'd1 << mw.ch);
                chk("wdata", o_ddr3_wdata, mw.d);
            end
        end
        if (o_rdata_valid != '0) begin
            if (rq.size() == 0) chk("rdata_valid_unexpected", 64'(o_rdata_valid), 64'd0);
            else begin
                mr = rq.pop_front();
                chk("rdata_valid", 64'(o_rdata_valid), 64'd1 << mr.ch);
                chk("rdata", o_rdata, mr.d);
                chk("rdata_latency", 64'(cyc), 64'(mr.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(o_cmd_valid), 64'd0);
        chk({tag, "_cmd"}, 64'(o_cmd), 64'd0);
        chk({tag, "_addr"}, 64'(o_addr), 64'd0);
        chk({tag, "_burst_cnt"}, 64'(o_cmd_burst_cnt), 64'd0);
        chk({tag, "_wdata_rd"}, 64'(o_wdata_rd), 64'd0);
        chk({tag, "_ddr3_wdata"}, o_ddr3_wdata, 64'd0);
        chk({tag, "_rdata"}, o_rdata, 64'd0);
        chk({tag, "_rdata_valid"}, 64'(o_rdata_valid), 64'd0);
        chk({tag, "_err"}, 64'(o_err), 64'd0);
        chk({tag, "_mask_ofly"}, 64'({o_data_mask, o_ofly_burst_len}), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] a, input logic [BLW-1:0] b);
        req_wr[ch] = wr;
        req_addr[ch*AW +: AW] = a;
        req_blen[ch*BLW +: BLW] = b;
        req_valid[ch] = 1'b1;
    endtask

    task automatic issue(input int ch, input logic wr, input logic [AW-1:0] a, input logic [BLW-1:0] b);
        cmd_t c;
        bit   got;
        c.cmd  = wr ? CMD_WR : CMD_RD;
        c.addr = a;
        c.blen = b;
        gq.push_back(ch);
        cq.push_back(c);
        set_req(ch, wr, a, b);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (o_req_ready[ch]) got = 1'b1;
        end
        chk("issue_grant_seen", 64'(got), 64'd1);
        req_valid[ch] = 1'b0;
    endtask

    task automatic wbeat(input int ch, input logic [DW-1:0] d);
        wd_t w;
        w.ch = ch;
        w.d  = d;
        wq.push_back(w);
        wdata[ch*DW +: DW] = d;
        datain_rdy = 1'b1;
        tick();
        datain_rdy = 1'b0;
    endtask

    task automatic rbeat(input int ch, input logic [DW-1:0] d);
        rd_t r;
        r.ch  = ch;
        r.d   = d;
        r.cyc = cyc + 1;
        rq.push_back(r);
        rdata = d;
        rdata_valid = 1'b1;
        tick();
        rdata_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        // Reset state
        rst = 1'b1;
        tick();
        check_zero("reset");
        tick();
        rst = 1'b0;
        init_done = 1'b1;
        tick();

        // Single write held on command port, then two data beats with a bubble
        issue(0, 1'b1, 26'h100, 5'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_cmd_valid", 64'(o_cmd_valid), 64'd1);
            chk("hold_cmd", 64'(o_cmd), 64'(CMD_WR));
            chk("hold_addr", 64'(o_addr), 64'h100);
            chk("hold_blen", 64'(o_cmd_burst_cnt), 64'd1);
            tick();
        end
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        wbeat(0, 64'h1111_0000_0000_1111);
        tick();
        wbeat(0, 64'h2222_0000_0000_2222);
        datain_rdy = 1'b1;
        repeat (3) tick();
        datain_rdy = 1'b0;

        // Round-robin over four continuously requesting read channels
        do_reset();
        tick();
        cmd_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_t c;
            c.cmd  = CMD_RD;
            c.addr = 26'h1000 + 26'(k % 4);
            c.blen = 5'((k % 4) + 1);
            gq.push_back(k % 4);
            cq.push_back(c);
        end
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 26'h1000 + 26'(k), 5'(k + 1));
        n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            tick();
            if (o_req_ready != '0) n++;
        end
        req_valid = '0;
        chk("rr_grant_count", 64'(n), 64'd5);
        repeat (3) tick();

        // Read routing: ch2 two bursts then ch1 one burst
        do_reset();
        tick();
        issue(2, 1'b0, 26'h200, 5'd2);
        issue(1, 1'b0, 26'h080, 5'd1);
        tick();
        rbeat(2, 64'hA);
        rbeat(2, 64'hB);
        tick();
        rbeat(2, 64'hC);
        rbeat(2, 64'hD);
        rbeat(1, 64'hE);
        tick();
        rbeat(1, 64'hF);
        repeat (2) tick();
        chk("routing_no_err", 64'(o_err), 64'd0);

        // Tag FIFO full: reads blocked, write still granted
        do_reset();
        tick();
        for (int i = 0; i < 8; i++) issue(0, 1'b0, 26'h300 + 26'(i), 5'd1);
        set_req(1, 1'b0, 26'h500, 5'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_req_ready[1]) seen++;
        end
        chk("tagfull_read_blocked", 64'(seen), 64'd0);
        issue(3, 1'b1, 26'h3F0, 5'd1);
        tick();
        wbeat(3, 64'h3333_3333_0000_0001);
        wbeat(3, 64'h3333_3333_0000_0002);
        repeat (4) tick();
        req_valid[1] = 1'b0;
        tick();

        // Read data with no outstanding tag, then reset mid write burst
        do_reset();
        tick();
        rdata = 64'hDEAD;
        rdata_valid = 1'b1;
        tick();
        rdata_valid = 1'b0;
        tick();
        chk("orphan_err", 64'(o_err), 64'd1);
        chk("orphan_dropped", o_rdata, 64'd0);
        issue(0, 1'b1, 26'h040, 5'd2);
        tick();
        wbeat(0, 64'h7777);
        wdata[0 +: DW] = 64'h8888;
        rst = 1'b1;
        tick();
        datain_rdy = 1'b1;
        #1;
        check_zero("rst_mid_wdata");
        tick();
        rst = 1'b0;
        repeat (4) tick();
        datain_rdy = 1'b0;
        tick();

        chk("grant_queue_drained", 64'(gq.size()), 64'd0);
        chk("cmd_queue_drained", 64'(cq.size()), 64'd0);
        chk("wdata_queue_drained", 64'(wq.size()), 64'd0);
        chk("rdata_queue_drained", 64'(rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
